score_input_conditioner: RTL

//  Conditions the raw score-event line from the Arduino before it reaches the

---
 rtl/score_input_conditioner_pkg.sv | 17 +
 rtl/sync_2ff.sv | 30 +++
 rtl/score_input_conditioner.sv | 139 +++++++++++++
 3 files changed

// File: rtl/score_input_conditioner_pkg.sv
// Shared encodings and defaults for the score input conditioner.
// Reused by the timer and display blocks of the clawgame processor.
package score_input_conditioner_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOW = 3'd0,
      ST_IDLE     = 3'd1,
      ST_DEB_HIGH = 3'd2,
      ST_HELD     = 3'd3,
      ST_DEB_LOW  = 3'd4
   } state_e;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
   localparam int unsigned DEF_LOCKOUT_CYCLES  = 50_000_000;
   localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input line.
// Both flops clear to 0 on synchronous reset.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/score_input_conditioner.sv
// Synchronizes, debounces and gates the Arduino score line into
// single-cycle increment_score / score_rejected pulses.
module score_input_conditioner
   import score_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       score_raw,
   input  logic       game_active,
   output logic       increment_score,
   output logic       score_rejected,
   output logic [7:0] accept_count
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);

   logic             s2;
   logic             primed;
   logic             qualified;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lock_q, lock_d;
   logic [1:0]       fill_q, fill_d;
   logic             inc_q, inc_d;
   logic             rej_q, rej_d;
   logic [7:0]       acc_q, acc_d;

   sync_2ff u_sync (
      .clock (clock),
      .reset (reset),
      .d     (score_raw),
      .q     (s2)
   );

   // The sync flops clear to 0, so s2 is only a real sample of the
   // line once two post-reset edges have refilled them.
   assign fill_d = {fill_q[0], 1'b1};
   assign primed = fill_q[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_WAIT_LOW;
         cnt_q   <= '0;
         lock_q  <= '0;
         fill_q  <= '0;
         inc_q   <= 1'b0;
         rej_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lock_q  <= lock_d;
         fill_q  <= fill_d;
         inc_q   <= inc_d;
         rej_q   <= rej_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      qualified = 1'b0;
      unique case (state_q)
         ST_WAIT_LOW: begin
            if (primed && !s2) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (s2) begin
               state_d = ST_DEB_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         ST_DEB_HIGH: begin
            if (!s2) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = ST_HELD;
               cnt_d     = '0;
               qualified = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HELD: begin
            if (!s2) begin
               state_d = ST_DEB_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         ST_DEB_LOW: begin
            if (s2) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_WAIT_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      inc_d  = 1'b0;
      rej_d  = 1'b0;
      acc_d  = acc_q;
      lock_d = (lock_q != '0) ? lock_q - CNT_ONE : '0;
      if (qualified) begin
         if (game_active && lock_q == '0) begin
            inc_d  = 1'b1;
            acc_d  = acc_q + 8'd1;
            lock_d = LOCK_LOAD;
         end else begin
            rej_d = 1'b1;
         end
      end
   end

   assign increment_score = inc_q;
   assign score_rejected  = rej_q;
   assign accept_count    = acc_q;

endmodule
